// File: rtl/alu_input_ctrl_if.sv
// Board-side bundle between switches/buttons/LEDs, the ALU and the input controller.
// The controller uses the slave modport; the board/top level drives through master.
interface alu_input_ctrl_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_sw;
    logic               i_btn_a;
    logic               i_btn_b;
    logic               i_btn_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_result;
    logic               o_result_valid;
    logic               o_op_err;
    logic [2:0]         o_state;

    modport slave (
        input  i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_result,
        output o_data_a, o_data_b, o_op, o_result, o_result_valid, o_op_err, o_state
    );

    modport master (
        output i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_result, o_result_valid, o_op_err, o_state
    );
endinterface

// File: rtl/alu_input_ctrl.sv
// Debounces the A/B/OP pushbuttons and sequences switch values into the ALU operand and
// opcode registers, then captures the ALU result and flags it valid.
module alu_input_ctrl #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OP           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    alu_input_ctrl_if.slave bus
);
    localparam int unsigned NB_CNT = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Bit 0 = A, bit 1 = B, bit 2 = OP.
    logic [2:0]        btn_raw;
    logic [2:0]        sync1_q, sync2_q;
    logic [2:0]        stable_q, stable_d;
    logic [2:0]        press_q, press_d;
    logic [NB_CNT-1:0] cnt_q [3];
    logic [NB_CNT-1:0] cnt_d [3];

    assign btn_raw = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};

    // The counter hitting the threshold flips the level; the press is the 0->1 flip only.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + NB_CNT'(1);
                end
            end
            press_d[i] = stable_d[i] & ~stable_q[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    function automatic logic valid_op(input logic [NB_OP-1:0] code);
        case (code)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
            NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
                valid_op = 1'b1;
            default: valid_op = 1'b0;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic               acc_a, acc_b, acc_op, op_ok;
    logic [NB_DATA-1:0] data_a_q, data_a_d, data_b_q, data_b_d, result_q, result_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               valid_q, valid_d, err_q, err_d;

    // Simultaneous presses: A beats B beats OP, losers are simply dropped.
    assign acc_a  = press_q[0];
    assign acc_b  = press_q[1] & ~press_q[0];
    assign acc_op = press_q[2] & ~press_q[1] & ~press_q[0];
    assign op_ok  = valid_op(bus.i_sw[NB_OP-1:0]);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= WAIT_A;
            data_a_q <= '0;
            data_b_q <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:  if (acc_a) state_d = WAIT_B;
            WAIT_B:  if (acc_b) state_d = WAIT_OP;
            WAIT_OP: begin
                if (acc_a)               state_d = WAIT_B;
                else if (acc_op && op_ok) state_d = CAPTURE;
            end
            CAPTURE: state_d = DONE;
            DONE: begin
                if (acc_a)                          state_d = WAIT_B;
                else if (acc_b || (acc_op && op_ok)) state_d = CAPTURE;
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            WAIT_A, WAIT_B, WAIT_OP, DONE: begin
                if (acc_a) begin
                    data_a_d = bus.i_sw;
                    valid_d  = 1'b0;
                    err_d    = 1'b0;
                end else if (acc_b && state_q != WAIT_A) begin
                    data_b_d = bus.i_sw;
                    valid_d  = 1'b0;
                    err_d    = 1'b0;
                end else if (acc_op && (state_q == WAIT_OP || state_q == DONE)) begin
                    if (op_ok) begin
                        op_d    = bus.i_sw[NB_OP-1:0];
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                result_d = bus.i_alu_result;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_data_a       = data_a_q;
    assign bus.o_data_b       = data_b_q;
    assign bus.o_op           = op_q;
    assign bus.o_result       = result_q;
    assign bus.o_result_valid = valid_q;
    assign bus.o_op_err       = err_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with a behavioural ALU closing the loop on
// o_data_a/o_data_b/o_op -> i_alu_result.
module tb_alu_input_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_input_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    alu_input_ctrl #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h26:   alu = a ^ b;
            6'h27:   alu = ~(a | b);
            6'h03:   alu = $signed(a) >>> b;
            6'h02:   alu = a >> b;
            default: alu = 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu(bus.o_data_a, bus.o_data_b, bus.o_op);

    typedef struct {
        logic [7:0] sw;
        int         btn;  // 0 = A, 1 = B, 2 = OP
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        logic       v;
        logic       e;
        logic [2:0] st;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string p, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input logic [7:0] res, input logic v,
                           input logic e, input logic [2:0] st);
        chk({p, ".a"},     32'(bus.o_data_a),       32'(a));
        chk({p, ".b"},     32'(bus.o_data_b),       32'(b));
        chk({p, ".op"},    32'(bus.o_op),           32'(op));
        chk({p, ".res"},   32'(bus.o_result),       32'(res));
        chk({p, ".valid"}, 32'(bus.o_result_valid), 32'(v));
        chk({p, ".err"},   32'(bus.o_op_err),       32'(e));
        chk({p, ".state"}, 32'(bus.o_state),        32'(st));
    endtask

    task automatic set_btn(input int btn, input logic val);
        case (btn)
            0:       bus.i_btn_a  = val;
            1:       bus.i_btn_b  = val;
            default: bus.i_btn_op = val;
        endcase
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int btn, input logic [7:0] sw);
        @(negedge clk);
        bus.i_sw = sw;
        set_btn(btn, 1'b1);
        cycles(8);
        set_btn(btn, 1'b0);
        cycles(14);
    endtask

    initial begin
        bus.i_sw     = '0;
        bus.i_btn_a  = 1'b0;
        bus.i_btn_b  = 1'b0;
        bus.i_btn_op = 1'b0;

        vecs[0]  = '{8'h0A, 0, 8'h0A, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd1};
        vecs[1]  = '{8'h0F, 1, 8'h0A, 8'h0F, 6'h00, 8'h00, 1'b0, 1'b0, 3'd2};
        vecs[2]  = '{8'h20, 2, 8'h0A, 8'h0F, 6'h20, 8'h19, 1'b1, 1'b0, 3'd4};
        vecs[3]  = '{8'h22, 2, 8'h0A, 8'h0F, 6'h22, 8'hFB, 1'b1, 1'b0, 3'd4};
        vecs[4]  = '{8'h3F, 2, 8'h0A, 8'h0F, 6'h22, 8'hFB, 1'b1, 1'b1, 3'd4};
        vecs[5]  = '{8'h05, 0, 8'h05, 8'h0F, 6'h22, 8'hFB, 1'b0, 1'b0, 3'd1};
        vecs[6]  = '{8'h03, 1, 8'h05, 8'h03, 6'h22, 8'hFB, 1'b0, 1'b0, 3'd2};
        vecs[7]  = '{8'h3F, 2, 8'h05, 8'h03, 6'h22, 8'hFB, 1'b0, 1'b1, 3'd2};
        vecs[8]  = '{8'h24, 2, 8'h05, 8'h03, 6'h24, 8'h01, 1'b1, 1'b0, 3'd4};
        vecs[9]  = '{8'h0C, 1, 8'h05, 8'h0C, 6'h24, 8'h04, 1'b1, 1'b0, 3'd4};
        vecs[10] = '{8'h25, 2, 8'h05, 8'h0C, 6'h25, 8'h0D, 1'b1, 1'b0, 3'd4};
        vecs[11] = '{8'h26, 2, 8'h05, 8'h0C, 6'h26, 8'h09, 1'b1, 1'b0, 3'd4};
        vecs[12] = '{8'h27, 2, 8'h05, 8'h0C, 6'h27, 8'hF2, 1'b1, 1'b0, 3'd4};
        vecs[13] = '{8'h11, 0, 8'h11, 8'h0C, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd1};
        vecs[14] = '{8'h22, 0, 8'h22, 8'h0C, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd1};
        vecs[15] = '{8'h30, 1, 8'h22, 8'h30, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd2};
        vecs[16] = '{8'h40, 1, 8'h22, 8'h40, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd2};
        vecs[17] = '{8'h33, 0, 8'h33, 8'h40, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd1};
        vecs[18] = '{8'h01, 1, 8'h33, 8'h01, 6'h27, 8'hF2, 1'b0, 1'b0, 3'd2};
        vecs[19] = '{8'h20, 2, 8'h33, 8'h01, 6'h20, 8'h34, 1'b1, 1'b0, 3'd4};

        cycles(3);
        chk_all("reset", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        cycles(2);

        for (int i = 0; i < 20; i++) begin
            press(vecs[i].btn, vecs[i].sw);
            chk_all($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                    vecs[i].res, vecs[i].v, vecs[i].e, vecs[i].st);
        end

        // Two-cycle glitch on A must not register.
        bus.i_sw = 8'h99;
        bus.i_btn_a = 1'b1;
        cycles(2);
        bus.i_btn_a = 1'b0;
        cycles(20);
        chk("glitch.state", 32'(bus.o_state), 32'd4);
        chk("glitch.a", 32'(bus.o_data_a), 32'h33);

        // Long hold: exactly one load, switch change mid-hold is not picked up.
        bus.i_sw = 8'h44;
        bus.i_btn_a = 1'b1;
        cycles(20);
        bus.i_sw = 8'h55;
        cycles(30);
        bus.i_btn_a = 1'b0;
        cycles(14);
        chk("hold.a", 32'(bus.o_data_a), 32'h44);
        chk("hold.state", 32'(bus.o_state), 32'd1);

        press(1, 8'h02);
        press(2, 8'h20);
        chk("pre_sim.res", 32'(bus.o_result), 32'h46);
        chk("pre_sim.state", 32'(bus.o_state), 32'd4);

        // A and B rise together in DONE: A wins, B is lost until re-pressed.
        bus.i_sw = 8'h77;
        bus.i_btn_a = 1'b1;
        bus.i_btn_b = 1'b1;
        cycles(10);
        bus.i_btn_a = 1'b0;
        cycles(20);
        chk("sim.a", 32'(bus.o_data_a), 32'h77);
        chk("sim.b", 32'(bus.o_data_b), 32'h02);
        chk("sim.state", 32'(bus.o_state), 32'd1);
        cycles(30);
        chk("sim_hold.state", 32'(bus.o_state), 32'd1);
        bus.i_btn_b = 1'b0;
        cycles(14);
        chk("sim_rel.state", 32'(bus.o_state), 32'd1);
        chk("sim_rel.b", 32'(bus.o_data_b), 32'h02);
        press(1, 8'h09);
        chk("sim_b.b", 32'(bus.o_data_b), 32'h09);
        chk("sim_b.state", 32'(bus.o_state), 32'd2);

        // Async reset while in CAPTURE.
        begin
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            bus.i_sw = 8'h20;
            bus.i_btn_op = 1'b1;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (bus.o_state == 3'd3) seen = 1'b1;
            end
            chk("cap_reached", 32'(seen), 32'd1);
            rst = 1'b1;
            #1;
            chk_all("rst_cap", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
            bus.i_btn_op = 1'b0;
            cycles(14);
            rst = 1'b0;
            cycles(2);
        end

        // Async reset while in DONE.
        press(0, 8'h10);
        press(1, 8'h20);
        press(2, 8'h20);
        chk("pre_rst.res", 32'(bus.o_result), 32'h30);
        chk("pre_rst.state", 32'(bus.o_state), 32'd4);
        rst = 1'b1;
        #1;
        chk_all("rst_done", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // B and OP are ignored in WAIT_A.
        press(1, 8'h12);
        press(2, 8'h20);
        chk_all("wait_a_ign", 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
